// File: rtl/rx_dibit_buffer.sv
// Receive-side frame capture buffer for demapped QPSK dibits.
// Fills a DEPTH x 2 RAM once per start pulse and exposes a 1-cycle registered read port.
module rx_dibit_buffer #(
    parameter int AW        = 10,
    parameter int DEPTH     = 1024,
    parameter int FRAME_LEN = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          start,
    input  logic [1:0]    data_in,
    input  logic          valid_in,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd_valid,
    output logic [1:0]    rd_data,
    output logic          rd_data_valid,
    output logic [AW:0]   wr_count,
    output logic          busy,
    output logic          full,
    output logic          overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_FULL
    } state_t;

    localparam logic [AW:0] LAST_COUNT = (AW+1)'(FRAME_LEN - 1);

    state_t        state_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic          wr_en;
    logic [1:0]    mem [DEPTH];

    // start wins over a coincident dibit, so that dibit is never written
    assign wr_en = en && valid_in && !start && (state_reg == S_FILL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            wr_ptr_reg <= '0;
            wr_count   <= '0;
            busy       <= 1'b0;
            full       <= 1'b0;
            overflow   <= 1'b0;
        end else if (en) begin
            if (start) begin
                state_reg  <= S_FILL;
                wr_ptr_reg <= '0;
                wr_count   <= '0;
                overflow   <= 1'b0;
                busy       <= 1'b1;
                full       <= 1'b0;
            end else begin
                case (state_reg)
                    S_FILL: begin
                        if (valid_in) begin
                            wr_ptr_reg <= wr_ptr_reg + AW'(1);
                            wr_count   <= wr_count + (AW+1)'(1);
                            if (wr_count == LAST_COUNT) begin
                                state_reg <= S_FULL;
                                busy      <= 1'b0;
                                full      <= 1'b1;
                            end
                        end
                    end
                    S_FULL: begin
                        if (valid_in) begin
                            overflow <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= data_in;
        end
    end

    // Nonblocking read of the array gives read-before-write on address collisions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data       <= 2'b00;
            rd_data_valid <= 1'b0;
        end else begin
            rd_data_valid <= en && rd_valid;
            if (en && rd_valid) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_rx_dibit_buffer.sv
// Directed-plus-random bench for rx_dibit_buffer, checked every cycle against a
// frame-queue reference model.
module tb_rx_dibit_buffer;

    localparam int AW = 10;
    localparam int DEPTH = 1024;
    localparam int FL = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    data_in = 2'b00;
    logic          valid_in = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_valid = 1'b0;
    logic [1:0]    rd_data;
    logic          rd_data_valid;
    logic [AW:0]   wr_count;
    logic          busy;
    logic          full;
    logic          overflow;

    rx_dibit_buffer #(.AW(AW), .DEPTH(DEPTH), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start),
        .data_in(data_in), .valid_in(valid_in),
        .rd_addr(rd_addr), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .wr_count(wr_count), .busy(busy), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model: the current frame is a queue of accepted dibits
    logic [1:0] frame_q[$];
    logic [1:0] ref_mem [DEPTH];
    bit         ref_known [DEPTH];
    bit         armed;
    bit         exp_ovf;
    bit         exp_rdv;
    logic [1:0] exp_rd;
    bit         exp_rd_known;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        armed = 0;
        frame_q.delete();
        exp_ovf = 0;
        exp_rdv = 0;
        exp_rd = 2'b00;
        exp_rd_known = 1;
    endtask

    task automatic check_outputs();
        chk("wr_count", int'(wr_count), frame_q.size());
        chk("busy", int'(busy), int'(armed && frame_q.size() < FL));
        chk("full", int'(full), int'(armed && frame_q.size() == FL));
        chk("overflow", int'(overflow), int'(exp_ovf));
        chk("rd_data_valid", int'(rd_data_valid), int'(exp_rdv));
        if (exp_rd_known) chk("rd_data", int'(rd_data), int'(exp_rd));
    endtask

    task automatic cyc(input bit e, input bit s, input bit v, input logic [1:0] d,
                       input bit rv, input int ra);
        en = e; start = s; valid_in = v; data_in = d;
        rd_valid = rv; rd_addr = AW'(ra);
        if (rst) begin
            model_reset();
        end else begin
            // read sees memory as it was before this cycle's write
            if (e && rv) begin
                exp_rdv = 1;
                exp_rd_known = ref_known[ra];
                exp_rd = ref_mem[ra];
            end else begin
                exp_rdv = 0;
            end
            if (e) begin
                if (s) begin
                    armed = 1;
                    frame_q.delete();
                    exp_ovf = 0;
                end else if (v && armed) begin
                    if (frame_q.size() < FL) begin
                        ref_mem[frame_q.size()] = d;
                        ref_known[frame_q.size()] = 1;
                        frame_q.push_back(d);
                    end else begin
                        exp_ovf = 1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_known[i] = 0;
        model_reset();

        // Reset for three cycles, then idle with stray valid dibits
        repeat (3) cyc(0, 0, 0, 2'b00, 0, 0);
        rst = 1'b0;
        repeat (4) cyc(1, 0, 1, 2'b11, 0, 0);

        // Full frame with addr%4 pattern, then read everything back-to-back
        cyc(1, 1, 0, 2'b00, 0, 0);
        for (int i = 0; i < FL; i++) cyc(1, 0, 1, 2'(i % 4), 0, 0);
        for (int a = 0; a < FL; a++) cyc(1, 0, 0, 2'b00, 1, a);
        cyc(1, 0, 0, 2'b00, 0, 0);

        // Overflow after full; memory must be untouched
        cyc(1, 0, 1, 2'($urandom), 0, 0);
        cyc(1, 0, 1, 2'($urandom), 1, 0);
        for (int i = 0; i < 12; i++) cyc(1, 0, 0, 2'b00, 1, int'($urandom_range(FL - 1, 0)));

        // New start clears overflow; gapped input with an enable gap mid-frame
        cyc(1, 1, 0, 2'b00, 0, 0);
        for (int i = 0; i < 90; i++)
            cyc(!(i >= 40 && i < 45), 0, (i % 3) == 0, 2'($urandom),
                1'($urandom), int'($urandom_range(40, 0)));

        // start and valid together: dibit dropped, next one lands at address 0
        cyc(1, 1, 1, 2'b10, 0, 0);
        cyc(1, 0, 1, 2'b01, 0, 0);
        cyc(1, 0, 0, 2'b00, 1, 0);
        cyc(1, 0, 0, 2'b00, 0, 0);
        chk("collision_addr0", int'(rd_data), 1);

        // Reset in the middle of a fill takes effect without a clock edge
        cyc(1, 1, 0, 2'b00, 0, 0);
        for (int i = 0; i < 500; i++) cyc(1, 0, 1, 2'($urandom), 1'($urandom), int'($urandom_range(FL - 1, 0)));
        rst = 1'b1;
        #2;
        chk("async_busy", int'(busy), 0);
        chk("async_wr_count", int'(wr_count), 0);
        model_reset();
        repeat (2) cyc(1, 0, 0, 2'b00, 0, 0);
        rst = 1'b0;

        // Fresh frame; first write collides with a read of address 0
        cyc(1, 1, 0, 2'b00, 0, 0);
        cyc(1, 0, 1, ~ref_mem[0], 1, 0);
        for (int i = 1; i < FL; i++)
            cyc(1, 0, 1, 2'($urandom), 1'($urandom), int'($urandom_range(FL - 1, 0)));
        for (int a = 0; a < FL; a++) cyc(1, 0, 0, 2'b00, 1, a);
        cyc(1, 0, 0, 2'b00, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rx_dibit_buffer.md
Name: rx_dibit_buffer

Overview:
- Receive-side capture buffer for 2-bit (QPSK dibit) demapped symbols; the write-side counterpart of the transmit dibit ROM.
- Writes one frame of incoming dibits into a DEPTH x 2 RAM at incrementing addresses and flags completion.
- Its read port uses the same addr/valid in, data/valid out, 1-cycle protocol as the transmit ROM, so the bench or a comparator can read both sides identically.

Parameters:
- AW, 10, address width.
- DEPTH, 1024, memory words (2**AW).
- FRAME_LEN, 1024, dibits per frame; legal range 1..DEPTH.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable; gates both write and read.
- start  in  1  single-cycle pulse; arms capture of a new frame.
- data_in  in  2  demapped dibit.
- valid_in  in  1  data_in qualifier.
- rd_addr  in  AW  read address.
- rd_valid  in  1  read request qualifier.
- rd_data  out  2  registered read data.
- rd_data_valid  out  1  high one cycle after an accepted read.
- wr_count  out  AW+1  dibits written in current frame.
- busy  out  1  high in FILL.
- full  out  1  high in FULL.
- overflow  out  1  sticky; a dibit arrived while FULL.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; wr_ptr=0, wr_count=0.
  - busy, full, overflow, rd_data and rd_data_valid all go to 0.
  - RAM contents are not cleared.
- States: IDLE, FILL, FULL. All transitions require en=1; with en=0, state, counters and flags hold.
- IDLE:
  - valid_in is ignored.
  - start goes to FILL with wr_ptr=0, wr_count=0, overflow=0.
- FILL (busy=1):
  - On en&&valid_in: RAM[wr_ptr]<=data_in; wr_ptr and wr_count increment.
  - When the write brings wr_count to FRAME_LEN, next state is FULL (full=1 the following cycle).
- FULL (full=1):
  - Writes are blocked.
  - en&&valid_in sets overflow=1 (sticky until next start or reset).
  - start goes to FILL as in IDLE.
- start while in FILL: restart the frame (wr_ptr=0, wr_count=0, overflow=0).
- start and valid_in in the same cycle: start has priority and that dibit is discarded (not written).
- Read port:
  - Independent of state; when en&&rd_valid, rd_data<=RAM[rd_addr] and rd_data_valid<=1 on the next edge.
  - Otherwise rd_data_valid<=0 and rd_data holds its last value.
  - Latency is exactly 1 cycle; back-to-back reads give one result per cycle.
- Same-address read and write in one cycle: read returns the old content (read-before-write).
- wr_ptr never exceeds FRAME_LEN-1 as a write address; no wrap within a frame.
- Reset mid-FILL: abort immediately; the next frame needs a new start.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, release -> all outputs 0, state IDLE; valid_in=1 with data 2'b11 while idle -> wr_count stays 0.
- Full frame, FRAME_LEN=1024:
  - start, then 1024 consecutive valid dibits with pattern addr%4 -> full=1 one cycle after the last write, wr_count=1024, busy=0.
  - Read addresses 0..1023 -> rd_data=addr%4, each rd_data_valid pulse 1 cycle after its request.
- Gapped input: valid_in asserted every third cycle, en toggled low for 5 cycles mid-frame -> only enabled valid cycles are written; wr_count matches the count of accepted dibits; no skipped addresses.
- Overflow: after full, 2 more valid dibits -> overflow=1 and RAM[0..1023] unchanged; new start -> overflow=0, busy=1, wr_count=0.
- Collision: start and valid_in (2'b10) in the same cycle -> dibit dropped, wr_count=0; next valid dibit 2'b01 lands at address 0.
- Reset mid-FILL: at wr_count=500 assert rst -> busy=0, wr_count=0 immediately.
  - Then start plus 1024 dibits completes normally.
  - Read-before-write check: read addr 0 while writing addr 0 -> old value returned.
